// File: rtl/prism_sit_programmer.sv
// Host-side sequencer: streams 32-bit words into the PRISM latch SIT over the
// latch/debug programming bus, then reads back entry 0 to confirm the load.
module prism_sit_programmer #(
  parameter int           WIDTH   = 48,
  parameter int           DEPTH   = 2,
  parameter logic [5:0]   LO_ADDR = 6'h10,
  parameter logic [5:0]   HI_ADDR = 6'h14
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic [31:0] latch_data,
  output logic        latch_wr,
  output logic [5:0]  debug_addr,
  output logic        debug_wr,
  input  logic [31:0] debug_rdata,
  output logic        busy,
  output logic        done,
  output logic        verify_err,
  output logic [5:0]  entry_cnt
);

  typedef enum logic [2:0] {
    IDLE, LO_WAIT, LO_WR, HI_WAIT, HI_WR, VRFY_LO, VRFY_HI, FIN
  } state_t;

  localparam logic [5:0] LAST_ENTRY = 6'(DEPTH - 1);

  state_t      state;
  logic        wr_q;
  logic [31:0] ent0_lo;
  logic [31:0] ent0_hi;

  // Only bits [WIDTH-33:0] of the high word exist in the SIT entry.
  function automatic logic [31:0] mask_hi(input logic [31:0] w);
    logic [31:0] m;
    m = 32'hFFFF_FFFF >> (64 - WIDTH);
    return w & m;
  endfunction

  // An abort arriving while a write state is presented kills that strobe too.
  assign latch_wr = wr_q & ~abort;
  assign debug_wr = wr_q & ~abort;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      in_ready   <= 1'b0;
      wr_q       <= 1'b0;
      latch_data <= '0;
      debug_addr <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      verify_err <= 1'b0;
      entry_cnt  <= '0;
      ent0_lo    <= '0;
      ent0_hi    <= '0;
    end else begin
      done <= 1'b0;
      wr_q <= 1'b0;
      if (abort && state != IDLE) begin
        state      <= IDLE;
        in_ready   <= 1'b0;
        busy       <= 1'b0;
        debug_addr <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              verify_err <= 1'b0;
              entry_cnt  <= '0;
              in_ready   <= 1'b1;
              busy       <= 1'b1;
              state      <= LO_WAIT;
            end
          end
          LO_WAIT: begin
            if (in_valid) begin
              in_ready   <= 1'b0;
              latch_data <= in_data;
              debug_addr <= LO_ADDR;
              wr_q       <= 1'b1;
              if (entry_cnt == 6'd0) ent0_lo <= in_data;
              state      <= LO_WR;
            end
          end
          LO_WR: begin
            in_ready <= 1'b1;
            state    <= HI_WAIT;
          end
          HI_WAIT: begin
            if (in_valid) begin
              in_ready   <= 1'b0;
              latch_data <= mask_hi(in_data);
              debug_addr <= HI_ADDR;
              wr_q       <= 1'b1;
              if (entry_cnt == 6'd0) ent0_hi <= mask_hi(in_data);
              state      <= HI_WR;
            end
          end
          HI_WR: begin
            if (entry_cnt == LAST_ENTRY) begin
              debug_addr <= LO_ADDR;
              state      <= VRFY_LO;
            end else begin
              entry_cnt <= entry_cnt + 6'd1;
              in_ready  <= 1'b1;
              state     <= LO_WAIT;
            end
          end
          // Entry 0 has been shifted to the read-back position by now.
          VRFY_LO: begin
            if (debug_rdata != ent0_lo) verify_err <= 1'b1;
            debug_addr <= HI_ADDR;
            state      <= VRFY_HI;
          end
          VRFY_HI: begin
            if (debug_rdata != ent0_hi) verify_err <= 1'b1;
            done  <= 1'b1;
            state <= FIN;
          end
          FIN: begin
            busy       <= 1'b0;
            debug_addr <= '0;
            state      <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
